// File: rtl/bf_bus_arbiter.sv
// External memory bus sequencer shared by the core and the host port.
// Two-way round-robin grant, then address phase, wait states, data phase, ack.
module bf_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       core_req,
    input  logic       core_we,
    input  logic       core_space,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_ack,
    output logic [7:0] core_rdata,
    input  logic       host_req,
    input  logic       host_we,
    input  logic       host_space,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic [7:0] bus_oe,
    output logic       bus_write,
    output logic       bus_addr,
    output logic       bus_instr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA,
        DONE
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state;
    logic       prio;
    logic       gnt_host;
    logic       lat_we;
    logic       lat_space;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;
    logic [3:0] wait_cnt;

    logic       req_any;
    logic       win_host;

    // prio = 1 means the host wins a tie
    always_comb begin
        req_any  = core_req | host_req;
        win_host = host_req & (~core_req | prio);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            gnt_host   <= 1'b0;
            lat_we     <= 1'b0;
            lat_space  <= 1'b0;
            lat_addr   <= 8'h00;
            lat_wdata  <= 8'h00;
            wait_cnt   <= 4'd0;
            core_rdata <= 8'h00;
            host_rdata <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ena && req_any) begin
                        gnt_host  <= win_host;
                        prio      <= ~win_host;
                        lat_we    <= win_host ? host_we : core_we;
                        lat_space <= win_host ? host_space : core_space;
                        lat_addr  <= win_host ? host_addr : core_addr;
                        lat_wdata <= win_host ? host_wdata : core_wdata;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= HAS_WAIT ? WAIT : DATA;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DATA: begin
                    if (!lat_we) begin
                        if (gnt_host) begin
                            host_rdata <= bus_din;
                        end else begin
                            core_rdata <= bus_din;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pins decode only from state and latched fields; no path from req
    always_comb begin
        bus_write = 1'b0;
        bus_addr  = 1'b0;
        bus_instr = 1'b0;
        bus_dout  = 8'h00;
        core_ack  = 1'b0;
        host_ack  = 1'b0;
        unique case (state)
            ADDR: begin
                bus_write = 1'b1;
                bus_addr  = 1'b1;
                bus_instr = lat_space;
                bus_dout  = lat_addr;
            end
            WAIT, DATA: begin
                bus_write = lat_we;
                bus_dout  = lat_we ? lat_wdata : 8'h00;
            end
            DONE: begin
                core_ack = ~gnt_host;
                host_ack = gnt_host;
            end
            default: begin
            end
        endcase
    end

    assign bus_oe = {8{bus_write}};
    assign busy   = (state != IDLE);

endmodule
